// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit with a configurable reset value.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: holds the last byte with a valid/ready handshake,
// a one-cycle framing-error pulse and a sticky overrun flag.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    input  logic                      rx_ready,
    input  logic                      ovr_clr,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_frame_err,
    output logic                      rx_overrun,
    output logic                      rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic [CW-1:0]             bitcnt;
    logic [IW-1:0]             bitidx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rxs;
    logic                      deliver;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_rxd (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    assign deliver = (state == STOP) && (bitcnt == LAST_CNT) && rxs;
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bitcnt       <= '0;
            bitidx       <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    bitcnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bitcnt == MID_CNT) begin
                        bitcnt <= '0;
                        bitidx <= '0;
                        // A start bit that is high again at mid-bit was a glitch
                        state  <= rxs ? IDLE : DATA;
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bitcnt == LAST_CNT) begin
                        bitcnt        <= '0;
                        shift[bitidx] <= rxs;
                        bitidx        <= bitidx + IW'(1);
                        if (bitidx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bitcnt == LAST_CNT) begin
                        bitcnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
                    end else begin
                        bitcnt <= bitcnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear first so a coinciding overrun event wins
            if (ovr_clr) begin
                rx_overrun <= 1'b0;
            end

            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with CLKS_PER_BIT=16, SYNC_STAGES=2.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rx_ready;
    logic       ovr_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int n_chk;
    int n_err;
    int cyc;
    int t_start;
    int rise_cyc;
    int fe_cnt;
    int fe_base;
    logic prev_valid;
    logic busy_seen;
    logic [7:0] accepted[$];

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .rx_ready     (rx_ready),
        .ovr_clr      (ovr_clr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive observers, sampled away from the active edge
    initial begin
        prev_valid = 1'b0;
        rise_cyc   = -1;
        fe_cnt     = 0;
        busy_seen  = 1'b0;
    end
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_frame_err) fe_cnt = fe_cnt + 1;
        if (rx_busy) busy_seen = 1'b1;
        if (rx_valid && rx_ready) accepted.push_back(rx_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        idle_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        reset    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        ovr_clr  = 1'b0;
        idle_clks(3);
        check_eq("reset_data", rx_data, 8'h00);
        check_eq("reset_valid", rx_valid, 0);
        check_eq("reset_fe", rx_frame_err, 0);
        check_eq("reset_ovr", rx_overrun, 0);
        check_eq("reset_busy", rx_busy, 0);
        reset = 1'b1;
        idle_clks(5);
        check_eq("idle_busy", rx_busy, 0);

        // 1: single byte, latency, handshake
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1);
        idle_clks(4);
        check_eq("t1_data", rx_data, 8'hA5);
        check_eq("t1_valid", rx_valid, 1);
        check_eq("t1_latency", ((rise_cyc - t_start) >= 154) && ((rise_cyc - t_start) <= 156), 1);
        consume();
        check_eq("t1_consumed", rx_valid, 0);
        check_eq("t1_data_hold", rx_data, 8'hA5);

        // 2: short glitch on the line
        fe_base   = fe_cnt;
        busy_seen = 1'b0;
        rxd = 1'b0;
        idle_clks(4);
        rxd = 1'b1;
        idle_clks(20);
        check_eq("t2_busy_seen", busy_seen, 1);
        check_eq("t2_busy", rx_busy, 0);
        check_eq("t2_valid", rx_valid, 0);
        check_eq("t2_fe", fe_cnt - fe_base, 0);

        // 3: framing error, break, recovery
        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        idle_clks(40);
        check_eq("t3_fe_pulses", fe_cnt - fe_base, 1);
        check_eq("t3_valid", rx_valid, 0);
        check_eq("t3_wait_busy", rx_busy, 1);
        rxd = 1'b1;
        idle_clks(5);
        check_eq("t3_idle", rx_busy, 0);
        send_frame(8'h55, 1'b1);
        idle_clks(4);
        check_eq("t3_data", rx_data, 8'h55);
        check_eq("t3_valid2", rx_valid, 1);
        check_eq("t3_fe_total", fe_cnt - fe_base, 1);
        consume();

        // 4: overrun and clear
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_clks(4);
        check_eq("t4_data", rx_data, 8'h11);
        check_eq("t4_valid", rx_valid, 1);
        check_eq("t4_ovr", rx_overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check_eq("t4_ovr_clr", rx_overrun, 0);
        check_eq("t4_data_keep", rx_data, 8'h11);
        consume();
        check_eq("t4_consumed", rx_valid, 0);

        // 5: streaming with ready held high
        accepted.delete();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        idle_clks(6);
        rx_ready = 1'b0;
        check_eq("t5_count", accepted.size(), 3);
        if (accepted.size() == 3) begin
            check_eq("t5_b0", accepted[0], 8'h00);
            check_eq("t5_b1", accepted[1], 8'hFF);
            check_eq("t5_b2", accepted[2], 8'h80);
        end
        check_eq("t5_ovr", rx_overrun, 0);
        check_eq("t5_valid", rx_valid, 0);

        // 6: reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        idle_clks(4);
        check_eq("t6_pre_valid", rx_valid, 1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("t6_busy_mid", rx_busy, 1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_data", rx_data, 8'h00);
        check_eq("t6_rst_valid", rx_valid, 0);
        check_eq("t6_rst_busy", rx_busy, 0);
        check_eq("t6_rst_fe", rx_frame_err, 0);
        check_eq("t6_rst_ovr", rx_overrun, 0);
        rxd = 1'b1;
        idle_clks(3);
        reset = 1'b1;
        idle_clks(3);
        send_frame(8'hC3, 1'b1);
        idle_clks(4);
        check_eq("t6_data", rx_data, 8'hC3);
        check_eq("t6_valid", rx_valid, 1);
        check_eq("t6_ovr", rx_overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
